redux_ctrl: RTL and testbench

- Multicycle control unit for the Redux-V 8-bit core: fetches and decodes instructions and drives the ALU select code, the register-file controls and the memory handshake.
- Owns PC and IR. The register file, the ALU and the unified instruction/data memory are external.
- Instruction format: op = ir[7:4], ra = ir[3:2], rb = ir[1:0], imm4 = ir[3:0].

---
 rtl/redux_ctrl.sv | 152 +++++++++++++++
 tb/tb_redux_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redux_ctrl.sv
// Multicycle fetch/decode/execute controller for the Redux-V 8-bit core; owns PC and IR.
// Latency: 3 cycles per ALU/LI/BRZR/JI instruction and 4 per LW/SW with zero-wait memory.
// Backpressure: mem_req and its address/data are held until mem_ack. REDUX_CTRL_ICOUNT_EN adds an icount port.
module redux_ctrl #(
    parameter int             MEM_W    = 8,
    parameter logic [MEM_W-1:0] RESET_PC = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             mem_req,
    output logic             mem_we,
    output logic [MEM_W-1:0] mem_addr,
    output logic [MEM_W-1:0] mem_wdata,
    input  logic [MEM_W-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [1:0]       rf_ra_sel,
    output logic [1:0]       rf_rb_sel,
    input  logic [MEM_W-1:0] rf_ra_data,
    input  logic [MEM_W-1:0] rf_rb_data,
    output logic             rf_we,
    output logic [1:0]       rf_wsel,
    output logic [MEM_W-1:0] rf_wdata,
    output logic [3:0]       alu_select,
    input  logic [MEM_W-1:0] alu_s,
    output logic [MEM_W-1:0] pc,
    output logic             halted
`ifdef REDUX_CTRL_ICOUNT_EN
    ,
    output logic [15:0]      icount
`endif
);

    localparam logic [3:0] OP_LW   = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_BRZR = 4'hC;
    localparam logic [3:0] OP_JI   = 4'hD;
    localparam logic [3:0] OP_LI   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEMW, HALT} state_t;

    state_t           state, state_nxt;
    logic [MEM_W-1:0] ir;
    logic [MEM_W-1:0] pc_nxt;
    logic [3:0]       op;
    logic [1:0]       ra, rb;
    logic [MEM_W-1:0] imm_sext;

    assign op         = ir[7:4];
    assign ra         = ir[3:2];
    assign rb         = ir[1:0];
    assign imm_sext   = {{(MEM_W-4){ir[3]}}, ir[3:0]};
    assign rf_ra_sel  = ra;
    assign rf_rb_sel  = rb;
    assign alu_select = (op <= 4'd9) ? op : 4'd0;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        rf_we     = 1'b0;
        rf_wsel   = 2'd0;
        rf_wdata  = '0;
        case (state)
            FETCH: begin
                if (mem_req && mem_ack) begin
                    state_nxt = DECODE;
                    pc_nxt    = pc + MEM_W'(1);
                end
            end
            DECODE: state_nxt = EXEC;
            EXEC: begin
                state_nxt = FETCH;
                case (op)
                    OP_LW, OP_SW: state_nxt = MEMW;
                    OP_BRZR: if (rf_ra_data == '0) pc_nxt = rf_rb_data;
                    OP_JI:   pc_nxt = pc + imm_sext;
                    OP_LI: begin
                        rf_we    = 1'b1;
                        rf_wsel  = ra;
                        rf_wdata = {{(MEM_W-2){1'b0}}, rb};
                    end
                    OP_HALT: state_nxt = HALT;
                    default: begin
                        rf_we    = 1'b1;
                        rf_wsel  = ra;
                        rf_wdata = alu_s;
                    end
                endcase
            end
            MEMW: begin
                if (mem_req && mem_ack) begin
                    state_nxt = FETCH;
                    if (!mem_we) begin
                        rf_we    = 1'b1;
                        rf_wsel  = ra;
                        rf_wdata = mem_rdata;
                    end
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == FETCH && mem_req && mem_ack)
                ir <= mem_rdata;
            if (state == EXEC && op == OP_HALT)
                halted <= 1'b1;
            // Requests are launched one cycle ahead so address/data are registered for the whole handshake.
            if (state == FETCH && !mem_req) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= pc;
            end else if (state_nxt == FETCH && state != FETCH) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= pc_nxt;
            end else if (state_nxt == MEMW && state == EXEC) begin
                mem_req  <= 1'b1;
                mem_we   <= (op == OP_SW);
                mem_addr <= rf_rb_data;
                if (op == OP_SW)
                    mem_wdata <= rf_ra_data;
            end else if (mem_req && mem_ack) begin
                mem_req <= 1'b0;
            end
        end
    end

`ifdef REDUX_CTRL_ICOUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            icount <= 16'd0;
        else if ((state == EXEC && state_nxt != MEMW) || (state == MEMW && mem_req && mem_ack))
            icount <= icount + 16'd1;
    end
`endif

endmodule

// File: tb/tb_redux_ctrl.sv
// Random and directed programs run on redux_ctrl against an instruction-level model; a monitor
// scoreboards memory transactions and register-file writes as the DUT presents them.
module tb_redux_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_req, mem_we, mem_ack;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0] rf_ra_sel, rf_rb_sel, rf_wsel;
    logic [7:0] rf_ra_data, rf_rb_data, rf_wdata, alu_s, pc;
    logic       rf_we, halted;
    logic [3:0] alu_select;
`ifdef REDUX_CTRL_ICOUNT_EN
    logic [15:0] icount;
`endif

    initial forever #5 clk = ~clk;

    redux_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rf_ra_sel(rf_ra_sel), .rf_rb_sel(rf_rb_sel), .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_wdata(rf_wdata),
        .alu_select(alu_select), .alu_s(alu_s), .pc(pc), .halted(halted)
`ifdef REDUX_CTRL_ICOUNT_EN
        , .icount(icount)
`endif
    );

    // External environment: unified memory, register file and ALU.
    logic [7:0] mem [256];
    logic [7:0] rf  [4];

    function automatic logic [7:0] alu_f(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
        case (sel)
            4'd0:    return ~a;
            4'd1:    return a & b;
            4'd2:    return a | b;
            4'd3:    return a ^ b;
            4'd4:    return a + b;
            4'd5:    return a - b;
            4'd6:    return a << 1;
            4'd7:    return a >> 1;
            4'd8:    return a * b;
            4'd9:    return {a[6:0], a[7]};
            default: return 8'h00;
        endcase
    endfunction

    assign rf_ra_data = rf[rf_ra_sel];
    assign rf_rb_data = rf[rf_rb_sel];
    assign alu_s      = alu_f(alu_select, rf_ra_data, rf_rb_data);

    typedef struct { logic [7:0] addr; logic we; logic [7:0] data; logic dacc; } mev_t;
    typedef struct { logic [1:0] sel; logic [7:0] data; logic [3:0] alu; } rev_t;
    mev_t mq[$];
    rev_t rq[$];

    int   n_vec = 0, n_err = 0;
    int   cyc = 0, first_ack = -1, data_len = -1;
    int   rf_cyc[$];
    int   wcnt = 0, wlo = 0, whi = 0;
    bit   armed = 1'b0;
    logic [7:0] last_pc;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Instruction-level reference: executes the program on private copies and queues expected events.
    task automatic model(input int maxi, output bit hlt, output int ni, output logic [7:0] fpc);
        logic [7:0] mm [256];
        logic [7:0] mr [4];
        logic [7:0] p, ir, v, ad;
        int op, a, b;
        mm = mem; mr = rf; p = 8'h00; hlt = 1'b0; ni = 0;
        while (!hlt && ni < maxi) begin
            ir = mm[p];
            mq.push_back(mev_t'{p, 1'b0, 8'h00, 1'b0});
            p  = p + 8'd1;
            op = int'(ir[7:4]); a = int'(ir[3:2]); b = int'(ir[1:0]);
            ni++;
            if (op <= 9) begin
                v = alu_f(ir[7:4], mr[a], mr[b]);
                rq.push_back(rev_t'{2'(a), v, ir[7:4]});
                mr[a] = v;
            end else if (op == 10) begin
                ad = mr[b];
                mq.push_back(mev_t'{ad, 1'b0, 8'h00, 1'b1});
                rq.push_back(rev_t'{2'(a), mm[ad], 4'd0});
                mr[a] = mm[ad];
            end else if (op == 11) begin
                mq.push_back(mev_t'{mr[b], 1'b1, mr[a], 1'b1});
                mm[mr[b]] = mr[a];
            end else if (op == 12) begin
                if (mr[a] == 8'h00) p = mr[b];
            end else if (op == 13) begin
                p = 8'(int'(p) + int'($signed(ir[3:0])));
            end else if (op == 14) begin
                rq.push_back(rev_t'{2'(a), 8'(b), 4'd0});
                mr[a] = 8'(b);
            end else begin
                hlt = 1'b1;
            end
        end
        fpc = p;
    endtask

    // One clock of environment activity: memory responds at negedge, regfile writes late in the cycle.
    task automatic tick();
        @(negedge clk);
        if (rst_n && mem_req) begin
            if (wcnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                if (mem_we) mem[mem_addr] = mem_wdata;
                wcnt = $urandom_range(whi, wlo);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                wcnt--;
            end
        end else begin
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = 8'($urandom);
        end
        #4;
        if (rst_n && rf_we) rf[rf_wsel] = rf_wdata;
    endtask

    // Monitor: pops and compares whenever the DUT completes a memory transaction or writes the regfile.
    initial begin
        mev_t e;
        rev_t r;
        bit   prev_pend;
        logic [7:0] prev_addr, prev_wdata;
        logic prev_we;
        int   req_cnt;
        prev_pend = 1'b0; req_cnt = 0;
        prev_addr = 8'h00; prev_wdata = 8'h00; prev_we = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_pend = 1'b0;
                req_cnt   = 0;
            end else begin
                cyc++;
                if (mem_req) req_cnt++;
                if (armed) begin
                    if (prev_pend) begin
                        chk("addr_hold", mem_addr, prev_addr);
                        chk("we_hold", mem_we, prev_we);
                        chk("wdata_hold", mem_wdata, prev_wdata);
                    end
                    if (mem_req && mem_ack) begin
                        chk("mem_expected", mq.size() > 0, 1);
                        if (mq.size() > 0) begin
                            e = mq.pop_front();
                            chk("mem_addr", mem_addr, e.addr);
                            chk("mem_we", mem_we, e.we);
                            if (e.we) chk("mem_wdata", mem_wdata, e.data);
                            if (e.dacc) data_len = req_cnt;
                            if (first_ack < 0) first_ack = cyc;
                        end
                    end
                    if (rf_we) begin
                        chk("rf_expected", rq.size() > 0, 1);
                        if (rq.size() > 0) begin
                            r = rq.pop_front();
                            chk("rf_wsel", rf_wsel, r.sel);
                            chk("rf_wdata", rf_wdata, r.data);
                            chk("alu_select", alu_select, r.alu);
                            rf_cyc.push_back(cyc);
                        end
                    end
                    if (mq.size() == 0 && rq.size() == 0) armed = 1'b0;
                end
                prev_pend  = mem_req && !mem_ack;
                prev_addr  = mem_addr;
                prev_we    = mem_we;
                prev_wdata = mem_wdata;
                if (mem_req && mem_ack) req_cnt = 0;
            end
        end
    end

    task automatic clear_env(input logic [7:0] fill);
        for (int i = 0; i < 256; i++) mem[i] = fill;
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    endtask

    // Entered with the DUT in reset; releases it, runs to completion, leaves it in reset.
    task automatic run_prog(input int maxi);
        bit eh;
        int en, n, bad;
        logic [7:0] ep;
        mq.delete(); rq.delete(); rf_cyc.delete();
        first_ack = -1; data_len = -1;
        model(maxi, eh, en, ep);
        wcnt  = $urandom_range(whi, wlo);
        armed = 1'b1;
        rst_n = 1'b1;
        n = 0;
        while (armed && n < maxi * 14 + 20) begin
            tick();
            n++;
        end
        chk("drained", armed, 0);
        armed = 1'b0;
        last_pc = pc;
        if (eh) begin
            repeat (3) tick();
            chk("halted", halted, 1);
            bad = 0;
            repeat (20) begin
                tick();
                if (mem_req) bad++;
            end
            chk("halt_no_req", bad, 0);
            chk("halt_pc", pc, ep);
            last_pc = pc;
`ifdef REDUX_CTRL_ICOUNT_EN
            chk("icount", icount, en);
`endif
        end
        rst_n = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        last_pc = 8'h00;
        clear_env(8'hF0);
        repeat (3) tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_wsel", rf_wsel, 0);
        chk("rst_rf_wdata", rf_wdata, 8'h00);
        chk("rst_pc", pc, 8'h00);
        chk("rst_halted", halted, 0);

        // Reset while a fetch is waiting on a slow memory.
        wlo = 6; whi = 6; wcnt = 6;
        rst_n = 1'b1;
        tick(); tick();
        chk("req_before_rst", mem_req, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_pc", pc, 8'h00);
        chk("rst_mid_halted", halted, 0);
        tick(); tick();

        // LI r1,2; LI r2,3; ADD r1,r2; HALT with zero-wait memory.
        clear_env(8'hF0);
        mem[0] = 8'hE6; mem[1] = 8'hEB; mem[2] = 8'h46; mem[3] = 8'hF0;
        wlo = 0; whi = 0;
        run_prog(10);
        chk("add_result", rf[1], 8'h05);
        chk("three_instr_cycles", (rf_cyc.size() == 3) ? rf_cyc[2] - first_ack + 1 : -1, 9);

        // LW r0,[r3] with three wait states.
        clear_env(8'hF0);
        mem[0] = 8'hA3; mem[8'h20] = 8'hA5; rf[3] = 8'h20;
        wlo = 3; whi = 3;
        run_prog(10);
        chk("lw_result", rf[0], 8'hA5);
        chk("lw_req_cycles", data_len, 4);

        // BRZR taken, then not taken.
        clear_env(8'hF0);
        mem[0] = 8'hC1; rf[1] = 8'h40;
        wlo = 0; whi = 1;
        run_prog(10);
        chk("brzr_taken_pc", last_pc, 8'h41);
        clear_env(8'hF0);
        mem[0] = 8'hC9; rf[1] = 8'h40; rf[2] = 8'h01;
        run_prog(10);
        chk("brzr_not_taken_pc", last_pc, 8'h02);

        // JI -2 from pc 0 wraps to FF; the store there patches address 0 with HALT.
        clear_env(8'h00);
        mem[0] = 8'hDE; mem[8'hFF] = 8'hB4; rf[1] = 8'hF0;
        wlo = 0; whi = 2;
        run_prog(10);
        chk("ji_wrap_store", mem[0], 8'hF0);
        chk("ji_wrap_pc", last_pc, 8'h01);

        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            for (int i = 0; i < 4; i++) rf[i] = 8'($urandom);
            wlo = 0; whi = $urandom_range(0, 3);
            run_prog(60);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
